pixel_row_collector: RTL and testbench

//  Sink side of the processed-pixel output interface (row, col, write_enable, pixel, done).

---
 rtl/pixel_row_collector.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_pixel_row_collector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_collector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_row_collector                                          |
// | Description : Sink for the processed-pixel output interface. Each incoming |
// |               row is captured into one bank of a ping-pong line buffer;    |
// |               completed rows are replayed as a valid/ready byte stream so  |
// |               a downstream consumer can drain the image at its own pace.   |
// | Option      : ROWCAP_CHECKSUM_EN adds row_sum[15:0], a wrapping 16-bit     |
// |               sum of the row's beats, valid on the row_last beat.          |
// | Ports       : clk, reset (async, active-high)                              |
// |               in_pxl_row/in_pxl_col/in_we/in_pixel/in_done : producer side |
// |               row_data/row_valid/row_ready/row_last/row_index : stream     |
// |               frame_done : frame fully drained after in_done               |
// |               overflow   : sticky, a write hit a full bank                 |
// |               seq_err    : sticky, column out of order or partial row      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_row_collector #(
    parameter int IMG_W = 300,
    parameter int IMG_H = 200,
    parameter int PIX_W = 8,
    parameter int COL_W = 9,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] in_pxl_row,
    input  logic [COL_W-1:0] in_pxl_col,
    input  logic             in_we,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_done,
    output logic [PIX_W-1:0] row_data,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             row_last,
    output logic [ROW_W-1:0] row_index,
    output logic             frame_done,
    output logic             overflow,
    output logic             seq_err
`ifdef ROWCAP_CHECKSUM_EN
    ,
    output logic [15:0]      row_sum
`endif
);

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] c_NUM_COLS = COL_W'(IMG_W);

    // Index widths must be able to address a full frame.
    generate
        if ((ROW_W < $clog2(IMG_H)) || (COL_W < $clog2(IMG_W + 1))) begin : g_bad_widths
            $error("pixel_row_collector: ROW_W/COL_W too narrow for IMG_H/IMG_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_SEND  = 2'd2
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] r_mem [2][IMG_W];
    logic [ROW_W-1:0] r_row_tag [2];
    logic [1:0]       r_bank_full;
    logic             r_wr_bank;
    logic             r_rd_bank;

    // Write side state
    logic [COL_W-1:0] r_exp_col;
    logic             r_overflow;
    logic             r_seq_err;
    logic             r_done_d;
    logic             r_done_seen;
    logic             r_frame_done;

    // Read side state
    rd_state_t        r_state;
    rd_state_t        w_state_next;
    logic [COL_W-1:0] r_rd_col;
    logic [PIX_W-1:0] r_rd_data;

    // Write side combinational
    logic             w_col_ok;
    logic             w_wr_drop;
    logic             w_wr_store;
    logic             w_wr_complete;
    logic             w_col_mismatch;
    logic [COL_W-1:0] w_exp_after_we;
    logic             w_done_rise;
    logic             w_partial_at_done;

    // Read side combinational
    logic             w_fire;
    logic             w_rd_en;
    logic [COL_W-1:0] w_rd_addr;
    logic             w_release;
    logic [1:0]       w_set_mask;
    logic [1:0]       w_clr_mask;

    // ------------------------------------------------------------------
    // Write side decode
    // ------------------------------------------------------------------
    always_comb begin
        w_col_ok       = (in_pxl_col < c_NUM_COLS);
        w_wr_drop      = in_we && r_bank_full[r_wr_bank];
        w_wr_store     = in_we && !r_bank_full[r_wr_bank] && w_col_ok;
        w_wr_complete  = w_wr_store && (in_pxl_col == c_LAST_COL);
        // Any column outside 0..IMG_W-1 can never equal the expected column,
        // so out-of-range writes are flagged here as well.
        w_col_mismatch = in_we && (in_pxl_col != r_exp_col);

        // Expected column follows the last column seen (resync), and returns
        // to 0 after the final column instead of counting past IMG_W.
        if (!in_we) begin
            w_exp_after_we = r_exp_col;
        end else if (in_pxl_col >= c_LAST_COL) begin
            w_exp_after_we = '0;
        end else begin
            w_exp_after_we = in_pxl_col + 1'b1;
        end

        // in_done may be a level; only its rising edge marks end of frame.
        w_done_rise       = in_done && !r_done_d;
        w_partial_at_done = w_done_rise && (w_exp_after_we != '0);
    end

    // Pixel storage has no reset: contents are simply overwritten.
    always_ff @(posedge clk) begin
        if (w_wr_store) begin
            r_mem[r_wr_bank][in_pxl_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank    <= 1'b0;
            r_exp_col    <= '0;
            r_overflow   <= 1'b0;
            r_seq_err    <= 1'b0;
            r_done_d     <= 1'b0;
            r_done_seen  <= 1'b0;
            r_frame_done <= 1'b0;
            r_row_tag[0] <= '0;
            r_row_tag[1] <= '0;
        end else begin
            r_done_d  <= in_done;
            // A partial row at end of frame is abandoned: its bank is never
            // marked full and the next frame restarts at column 0.
            r_exp_col <= w_partial_at_done ? '0 : w_exp_after_we;

            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_col_mismatch || w_partial_at_done) begin
                r_seq_err <= 1'b1;
            end
            if (w_wr_complete) begin
                r_row_tag[r_wr_bank] <= in_pxl_row;
                r_wr_bank            <= ~r_wr_bank;
            end

            if (w_done_rise) begin
                r_done_seen <= 1'b1;
            end else if (in_we) begin
                r_done_seen <= 1'b0;
            end

            if (in_we) begin
                r_frame_done <= 1'b0;
            end else if (r_done_seen && (r_bank_full == 2'b00) && (r_state == R_IDLE)) begin
                r_frame_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    assign w_fire = (r_state == R_SEND) && row_ready;

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_rd_col;
        w_release    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                // r_rd_col is 0 here; the RAM output lands next cycle.
                w_rd_en      = 1'b1;
                w_state_next = R_SEND;
            end
            R_SEND: begin
                if (row_ready) begin
                    if (r_rd_col == c_LAST_COL) begin
                        w_release    = 1'b1;
                        w_state_next = R_IDLE;
                    end else begin
                        // Prefetch the next column so beats stay back-to-back.
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_rd_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_col  <= '0;
            r_rd_bank <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (r_state == R_IDLE) begin
                r_rd_col <= '0;
            end else if (w_fire && (r_rd_col != c_LAST_COL)) begin
                r_rd_col <= r_rd_col + 1'b1;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            // Holding the read register while stalled keeps row_data stable.
            if (w_rd_en) begin
                r_rd_data <= r_mem[r_rd_bank][w_rd_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank occupancy. Release by the reader wins over a same-cycle set.
    // ------------------------------------------------------------------
    assign w_set_mask = w_wr_complete ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr_mask = w_release     ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign row_valid  = (r_state == R_SEND);
    assign row_data   = r_rd_data;
    assign row_last   = row_valid && (r_rd_col == c_LAST_COL);
    assign row_index  = row_valid ? r_row_tag[r_rd_bank] : '0;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign seq_err    = r_seq_err;

`ifdef ROWCAP_CHECKSUM_EN
    logic [15:0] r_sum_acc;
    logic [15:0] w_sum;

    // Running sum including the beat currently presented; restarts at column 0.
    assign w_sum   = ((r_rd_col == '0) ? 16'd0 : r_sum_acc) + 16'(row_data);
    assign row_sum = row_valid ? w_sum : 16'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum_acc <= 16'd0;
        end else if (w_fire) begin
            r_sum_acc <= w_sum;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_collector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_row_collector                                       |
// | Description : Directed self-checking bench for pixel_row_collector.        |
// |               A negedge monitor compares every streamed beat with a queue  |
// |               of expected beats and checks stall stability.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pixel_row_collector;

    localparam int c_W = 300;

    logic       clk;
    logic       reset;
    logic [7:0] in_pxl_row;
    logic [8:0] in_pxl_col;
    logic       in_we;
    logic [7:0] in_pixel;
    logic       in_done;
    logic [7:0] row_data;
    logic       row_valid;
    logic       row_ready;
    logic       row_last;
    logic [7:0] row_index;
    logic       frame_done;
    logic       overflow;
    logic       seq_err;
`ifdef ROWCAP_CHECKSUM_EN
    logic [15:0] row_sum;
    logic [15:0] last_row_sum;
`endif

    pixel_row_collector dut (
        .clk        (clk),
        .reset      (reset),
        .in_pxl_row (in_pxl_row),
        .in_pxl_col (in_pxl_col),
        .in_we      (in_we),
        .in_pixel   (in_pixel),
        .in_done    (in_done),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_last   (row_last),
        .row_index  (row_index),
        .frame_done (frame_done),
        .overflow   (overflow),
        .seq_err    (seq_err)
`ifdef ROWCAP_CHECKSUM_EN
        ,
        .row_sum    (row_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] row;
        logic [7:0] data;
        logic       last;
        logic       chk;
    } beat_t;

    beat_t exp_q[$];

    int    n_checks = 0;
    int    n_err    = 0;
    int    fire_cnt = 0;
    int    first_valid_cyc = -1;
    int    last_fire_cyc   = 0;
    int    last_wr_cyc     = 0;
    logic  stall_prev = 1'b0;
    logic [16:0] prev_vec = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'(c);
            1:       return 8'(r * 3 + c * 5);
            default: return 8'hFF;
        endcase
    endfunction

    // Monitor: every fired beat must match the head of the expected queue;
    // a stalled beat must be unchanged on the next cycle.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", 32'({row_valid, row_index, row_last, row_data}),
                      32'({1'b1, prev_vec}));
            end
            if (row_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (row_valid && row_ready) begin
                fire_cnt++;
                last_fire_cyc = cyc;
`ifdef ROWCAP_CHECKSUM_EN
                if (row_last) last_row_sum = row_sum;
`endif
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_meta row%0d", e.row), 32'({row_index, row_last}),
                          32'({e.row, e.last}));
                    if (e.chk) check($sformatf("beat_data row%0d", e.row), 32'(row_data), 32'(e.data));
                end
            end
            stall_prev = row_valid && !row_ready;
            prev_vec   = {row_index, row_last, row_data};
        end
    end

    task automatic put(input int r, input int c, input logic [7:0] p);
        in_we      = 1'b1;
        in_pxl_row = 8'(r);
        in_pxl_col = 9'(c);
        in_pixel   = p;
        @(posedge clk); #1;
        last_wr_cyc = cyc;
        in_we = 1'b0;
    endtask

    task automatic push_row(input int r, input int kind);
        for (int c = 0; c < c_W; c++)
            exp_q.push_back('{row: 8'(r), data: pix_of(kind, r, c), last: (c == c_W - 1), chk: 1'b1});
    endtask

    task automatic write_row(input int r, input int kind, input int gap);
        for (int c = 0; c < c_W; c++) put(r, c, pix_of(kind, r, c));
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_we   = 1'b0;
        in_done = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin : stim
        int base;
        reset = 1'b1; in_we = 1'b0; in_done = 1'b0; row_ready = 1'b0;
        in_pxl_row = '0; in_pxl_col = '0; in_pixel = '0;
`ifdef ROWCAP_CHECKSUM_EN
        last_row_sum = '0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", 32'({row_valid, row_last, row_index, row_data, frame_done, overflow, seq_err}), 32'd0);

        // 1: single row, pixel = col[7:0], free-running consumer
        row_ready = 1'b1;
        @(posedge clk); #1;
        first_valid_cyc = -1;
        push_row(0, 0);
        write_row(0, 0, 0);
        wait_drain("t1_drain", 1000);
        check("t1_latency", 32'(first_valid_cyc - last_wr_cyc), 32'd2);
        check("t1_back_to_back", 32'(last_fire_cyc - first_valid_cyc), 32'd299);
        check("t1_flags", 32'({overflow, seq_err}), 32'd0);

        // 2: full frame with short inter-row gaps, then in_done
        do_reset();
        row_ready = 1'b1;
        base = fire_cnt;
        for (int r = 0; r < 200; r++) begin
            push_row(r, 1);
            write_row(r, 1, 4);
        end
        in_done = 1'b1; @(posedge clk); #1; in_done = 1'b0;
        for (int i = 0; i < 2000 && !frame_done; i++) @(negedge clk);
        check("t2_frame_done", 32'(frame_done), 32'd1);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_beats", 32'(fire_cnt - base), 32'd60000);
        check("t2_flags", 32'({overflow, seq_err}), 32'd0);

        // 3: consumer stalled while three rows arrive
        do_reset();
        row_ready = 1'b0;
        push_row(0, 1);
        push_row(1, 1);
        write_row(0, 1, 0);
        write_row(1, 1, 0);
        write_row(2, 1, 0);
        @(negedge clk);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_hold_row0", 32'({row_valid, row_index}), 32'({1'b1, 8'd0}));
        check("t3_seq_err", 32'(seq_err), 32'd0);
        @(posedge clk); #1 row_ready = 1'b1;
        wait_drain("t3_drain", 2000);
        repeat (10) @(negedge clk);
        check("t3_idle", 32'(row_valid), 32'd0);

        // 4: alternating ready
        do_reset();
        row_ready = 1'b0;
        push_row(3, 1);
        push_row(4, 1);
        write_row(3, 1, 0);
        write_row(4, 1, 0);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1 row_ready = ~row_ready;
        end
        #1 check("t4_drain", 32'(exp_q.size()), 32'd0);
        row_ready = 1'b1;

        // 5a: columns 10 and 11 skipped
        do_reset();
        for (int c = 0; c < c_W; c++)
            exp_q.push_back('{row: 8'd7, data: pix_of(0, 7, c), last: (c == c_W - 1), chk: (c != 10 && c != 11)});
        for (int c = 0; c < c_W; c++)
            if (c != 10 && c != 11) put(7, c, pix_of(0, 7, c));
        check("t5_seq_err", 32'(seq_err), 32'd1);
        wait_drain("t5_drain", 1000);
        check("t5_overflow", 32'(overflow), 32'd0);

        // 5b: in_done after a partial row
        do_reset();
        for (int c = 0; c <= 150; c++) put(8, c, pix_of(1, 8, c));
        in_done = 1'b1; @(posedge clk); #1; in_done = 1'b0;
        repeat (10) @(negedge clk);
        check("t5b_seq_err", 32'(seq_err), 32'd1);
        check("t5b_no_row", 32'(row_valid), 32'd0);
        check("t5b_frame_done", 32'(frame_done), 32'd1);
        put(0, 0, 8'h00);
        check("t5b_done_clear", 32'(frame_done), 32'd0);

        // 6: reset in the middle of a streaming row
        do_reset();
        push_row(5, 1);
        write_row(5, 1, 0);
        base = fire_cnt;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (fire_cnt - base >= 100) break;
        end
        check("t6_reach_beat100", 32'(fire_cnt - base >= 100), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_async_outputs", 32'({row_valid, row_last, row_index, row_data, frame_done, overflow, seq_err}), 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        push_row(6, 0);
        write_row(6, 0, 0);
        wait_drain("t6_post_reset", 1000);
        check("t6_flags", 32'({overflow, seq_err}), 32'd0);

`ifdef ROWCAP_CHECKSUM_EN
        push_row(9, 2);
        write_row(9, 2, 0);
        wait_drain("cs_drain", 1000);
        check("cs_row_sum", 32'(last_row_sum), 32'h2AD4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
